// File: rtl/axi_burst_interface_pkg.sv
// Shared types and constants for the AXI3 burst interface: FSM states,
// address-phase payload and the cache-line base helper.
package axi_burst_interface_pkg;

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_AR   = 2'd1,
    RD_R    = 2'd2
  } rd_state_e;

  typedef enum logic [1:0] {
    WR_IDLE      = 2'd0,
    WR_ADDR_DATA = 2'd1,
    WR_B         = 2'd2
  } wr_state_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_WORD  = 3'd2;
  localparam logic [1:0] RESP_OKAY      = 2'b00;

  // Address-phase payload shared by the AR and AW channels
  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  len;
    logic [2:0]  size;
  } ax_cmd_t;

  function automatic logic [31:0] line_base(input logic [31:0] addr,
                                            input int unsigned off_bits);
    return addr & ~((32'd1 << off_bits) - 32'd1);
  endfunction

endpackage

// File: rtl/axi_beat_counter.sv
// Beat counter for one AXI data channel: loads the burst length, counts
// accepted beats and flags the final beat.
module axi_beat_counter (
  input  logic       clk,
  input  logic       reset,
  input  logic       load_i,
  input  logic [3:0] len_i,
  input  logic       inc_i,
  output logic [3:0] cnt_o,
  output logic       last_o
);

  logic [3:0] cnt_q;
  logic [3:0] len_q;

  // Wraps to zero after the final beat so the next burst starts clean
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= 4'd0;
      len_q <= 4'd0;
    end else if (load_i) begin
      cnt_q <= 4'd0;
      len_q <= len_i;
    end else if (inc_i) begin
      cnt_q <= last_o ? 4'd0 : cnt_q + 4'd1;
    end
  end

  assign cnt_o  = cnt_q;
  assign last_o = (cnt_q == len_q);

endmodule

// File: rtl/axi_burst_interface.sv
// Cache-line / single-beat AXI3 master: independent read and write FSMs with
// a same-line read-after-write hazard stall.
module axi_burst_interface
  import axi_burst_interface_pkg::*;
#(
  parameter int unsigned LINE_BEATS = 8,
  parameter logic [3:0]  AXI_ID     = 4'b0
) (
  input  logic        clk,
  input  logic        reset,
  // read request port
  input  logic        rd_req,
  input  logic        rd_single,
  input  logic [1:0]  rd_size,
  input  logic [31:0] rd_addr,
  output logic        rd_gnt,
  output logic        rd_beat_valid,
  output logic [31:0] rd_beat_data,
  output logic [3:0]  rd_beat_idx,
  output logic        rd_done,
  output logic        rd_err,
  // write request port
  input  logic        wr_req,
  input  logic        wr_single,
  input  logic [1:0]  wr_size,
  input  logic [3:0]  wr_strb,
  input  logic [31:0] wr_addr,
  output logic        wr_gnt,
  output logic [3:0]  wr_beat_idx,
  output logic        wr_data_ack,
  input  logic [31:0] wr_data,
  output logic        wr_done,
  output logic        wr_err,
  // AXI read address
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [3:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  // AXI read data
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  // AXI write address
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [3:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic [1:0]  awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,
  // AXI write data
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  // AXI write response
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  localparam int unsigned LINE_OFF  = $clog2(LINE_BEATS) + 2;
  localparam logic [3:0]  BURST_LEN = 4'(LINE_BEATS - 1);

  rd_state_e  rd_state_q;
  wr_state_e  wr_state_q;
  ax_cmd_t    ar_q, aw_q;
  ax_cmd_t    rd_cmd_c, wr_cmd_c;
  logic       arvalid_q, rready_q, rd_err_q;
  logic       awvalid_q, wvalid_q, bready_q;
  logic [3:0] wstrb_q;
  logic [3:0] rd_cnt, wr_cnt;
  logic       rd_last, wr_last;
  logic       rd_hazard_c, rd_beat_c, rd_beat_err_c;
  logic       aw_done_c, w_done_c;
  logic [31:0] wr_line_src_c;

  // Address-phase payload for a new request: line-aligned INCR burst or raw single
  always_comb begin
    rd_cmd_c.addr = rd_single ? rd_addr : line_base(rd_addr, LINE_OFF);
    rd_cmd_c.len  = rd_single ? 4'd0 : BURST_LEN;
    rd_cmd_c.size = rd_single ? {1'b0, rd_size} : AXI_SIZE_WORD;
    wr_cmd_c.addr = wr_single ? wr_addr : line_base(wr_addr, LINE_OFF);
    wr_cmd_c.len  = wr_single ? 4'd0 : BURST_LEN;
    wr_cmd_c.size = wr_single ? {1'b0, wr_size} : AXI_SIZE_WORD;
  end

  // A write in flight, or one being granted this cycle, blocks reads to its line
  always_comb begin
    wr_line_src_c = (wr_state_q != WR_IDLE) ? aw_q.addr : wr_addr;
    rd_hazard_c   = ((wr_state_q != WR_IDLE) || wr_req) &&
                    (line_base(rd_addr, LINE_OFF) == line_base(wr_line_src_c, LINE_OFF));
  end

  assign rd_gnt        = ~reset & (rd_state_q == RD_IDLE) & rd_req & ~rd_hazard_c;
  assign rd_beat_c     = ~reset & rready_q & rvalid;
  assign rd_beat_err_c = (rresp != RESP_OKAY) || (rlast != rd_last);
  assign rd_beat_valid = rd_beat_c;
  assign rd_beat_data  = rdata;
  assign rd_beat_idx   = rd_cnt;
  assign rd_done       = rd_beat_c & rd_last;
  assign rd_err        = rd_done & (rd_err_q | rd_beat_err_c);

  axi_beat_counter u_rd_cnt (
    .clk    (clk),
    .reset  (reset),
    .load_i (rd_gnt),
    .len_i  (rd_cmd_c.len),
    .inc_i  (rd_beat_c),
    .cnt_o  (rd_cnt),
    .last_o (rd_last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_state_q <= RD_IDLE;
      ar_q       <= '0;
      arvalid_q  <= 1'b0;
      rready_q   <= 1'b0;
      rd_err_q   <= 1'b0;
    end else begin
      case (rd_state_q)
        RD_IDLE: begin
          if (rd_gnt) begin
            ar_q       <= rd_cmd_c;
            arvalid_q  <= 1'b1;
            rd_err_q   <= 1'b0;
            rd_state_q <= RD_AR;
          end
        end
        RD_AR: begin
          if (arready) begin
            arvalid_q  <= 1'b0;
            rready_q   <= 1'b1;
            rd_state_q <= RD_R;
          end
        end
        RD_R: begin
          if (rd_beat_c) begin
            if (rd_last) begin
              rready_q   <= 1'b0;
              rd_err_q   <= 1'b0;
              rd_state_q <= RD_IDLE;
            end else begin
              rd_err_q <= rd_err_q | rd_beat_err_c;
            end
          end
        end
        default: rd_state_q <= RD_IDLE;
      endcase
    end
  end

  assign wr_gnt      = ~reset & (wr_state_q == WR_IDLE) & wr_req;
  assign wr_data_ack = ~reset & wvalid_q & wready;
  assign wr_beat_idx = wr_cnt;
  assign wr_done     = ~reset & bready_q & bvalid;
  assign wr_err      = wr_done & (bresp != RESP_OKAY);
  assign aw_done_c   = ~awvalid_q | awready;
  assign w_done_c    = ~wvalid_q | (wready & wr_last);

  axi_beat_counter u_wr_cnt (
    .clk    (clk),
    .reset  (reset),
    .load_i (wr_gnt),
    .len_i  (wr_cmd_c.len),
    .inc_i  (wr_data_ack),
    .cnt_o  (wr_cnt),
    .last_o (wr_last)
  );

  // AW and W retire independently; B is awaited only once both are done
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_state_q <= WR_IDLE;
      aw_q       <= '0;
      wstrb_q    <= 4'd0;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      bready_q   <= 1'b0;
    end else begin
      case (wr_state_q)
        WR_IDLE: begin
          if (wr_gnt) begin
            aw_q       <= wr_cmd_c;
            wstrb_q    <= wr_single ? wr_strb : 4'hF;
            awvalid_q  <= 1'b1;
            wvalid_q   <= 1'b1;
            wr_state_q <= WR_ADDR_DATA;
          end
        end
        WR_ADDR_DATA: begin
          if (awvalid_q && awready) awvalid_q <= 1'b0;
          if (wr_data_ack && wr_last) wvalid_q <= 1'b0;
          if (aw_done_c && w_done_c) begin
            bready_q   <= 1'b1;
            wr_state_q <= WR_B;
          end
        end
        WR_B: begin
          if (bvalid) begin
            bready_q   <= 1'b0;
            wr_state_q <= WR_IDLE;
          end
        end
        default: wr_state_q <= WR_IDLE;
      endcase
    end
  end

  assign arid    = AXI_ID;
  assign araddr  = ar_q.addr;
  assign arlen   = ar_q.len;
  assign arsize  = ar_q.size;
  assign arburst = AXI_BURST_INCR;
  assign arlock  = 2'b00;
  assign arcache = 4'b0000;
  assign arprot  = 3'b000;
  assign arvalid = arvalid_q;
  assign rready  = rready_q;

  assign awid    = AXI_ID;
  assign awaddr  = aw_q.addr;
  assign awlen   = aw_q.len;
  assign awsize  = aw_q.size;
  assign awburst = AXI_BURST_INCR;
  assign awlock  = 2'b00;
  assign awcache = 4'b0000;
  assign awprot  = 3'b000;
  assign awvalid = awvalid_q;

  assign wid     = AXI_ID;
  assign wdata   = wr_data;
  assign wstrb   = wstrb_q;
  assign wlast   = wvalid_q & wr_last;
  assign wvalid  = wvalid_q;
  assign bready  = bready_q;

endmodule
